// File: rtl/uart_boot_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding, stream
// phase, UART register map and host response codes.
package uart_boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_READ,
        S_STORE,
        S_SEND,
        S_DONE,
        S_ERROR
    } state_t;

    // Which part of the host stream the next complete byte group belongs to
    typedef enum logic [1:0] {
        PH_LENGTH,
        PH_DATA,
        PH_CSUM
    } phase_t;

    localparam logic [7:0] ADDR_RX_DATA  = 8'd0;
    localparam logic [7:0] ADDR_RX_AVAIL = 8'd4;
    localparam logic [7:0] ADDR_TX_DATA  = 8'd8;

    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

endpackage

// File: rtl/uart_boot_loader.sv
// UART boot loader: polls the UART, assembles little-endian words from the
// host stream (length word, then payload words), writes them to memory from
// BASE_ADDRESS upward and answers the host with ACK or NAK.
// Optional feature macro: UART_BOOT_CHECKSUM_EN -- a trailing XOR checksum
// byte over the payload is read and checked before the response.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          MAX_WORDS    = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        uart_selected,
    output logic [7:0]  uart_address,
    output logic        uart_read,
    output logic        uart_write,
    output logic [7:0]  uart_write_data,
    input  logic [31:0] uart_read_data,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write
);

    localparam int WCW = $clog2(MAX_WORDS + 1);

`ifdef UART_BOOT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    state_t              r_state, w_next;
    phase_t              r_phase;
    logic [3:0][7:0]     r_lanes;
    logic [1:0]          r_byte_cnt;
    logic [WCW-1:0]      r_word_cnt;
    logic [WCW-1:0]      r_len;
    logic [7:0]          r_csum;
    logic [7:0]          r_resp;
    logic                r_done;
    logic                r_error;

    logic [7:0]          w_byte;
    logic [31:0]         w_word;
    logic                w_last_lane;
    logic                w_len_big;
    logic                w_len_zero;
    logic                w_last_word;
    logic                w_csum_ok;
    logic                w_unused;

    // Only the low byte of RX data and bit 0 of RX available carry meaning
    assign w_unused    = ^uart_read_data[31:8];
    assign w_byte      = uart_read_data[7:0];
    // Word as it will look once the byte being read lands in lane 3
    assign w_word      = {w_byte, r_lanes[2], r_lanes[1], r_lanes[0]};
    assign w_last_lane = (r_byte_cnt == 2'd3);
    assign w_len_big   = (w_word > 32'(MAX_WORDS));
    assign w_len_zero  = (w_word == 32'd0);
    assign w_last_word = (WCW'(r_word_cnt + 1'b1) == r_len);
    assign w_csum_ok   = (w_byte == r_csum);

    assign busy          = (r_state != S_IDLE);
    assign uart_selected = busy;
    assign done          = r_done;
    assign error         = r_error;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and bus strobes; every strobe is decoded from the state alone
    always_comb begin
        w_next          = r_state;
        uart_address    = 8'd0;
        uart_read       = 1'b0;
        uart_write      = 1'b0;
        uart_write_data = 8'd0;
        mem_address     = 32'd0;
        mem_write_data  = 32'd0;
        mem_write       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_POLL;
            end
            S_POLL: begin
                uart_read    = 1'b1;
                uart_address = ADDR_RX_AVAIL;
                if (uart_read_data[0]) w_next = S_READ;
            end
            S_READ: begin
                uart_read    = 1'b1;
                uart_address = ADDR_RX_DATA;
                if (r_phase == PH_CSUM)
                    w_next = S_SEND;
                else if (w_last_lane) begin
                    if (r_phase == PH_DATA)
                        w_next = S_STORE;
                    else if (w_len_big || (w_len_zero && !CSUM_EN))
                        w_next = S_SEND;
                    else
                        w_next = S_POLL;
                end else
                    w_next = S_POLL;
            end
            S_STORE: begin
                mem_write      = 1'b1;
                mem_address    = BASE_ADDRESS + (32'(r_word_cnt) << 2);
                mem_write_data = r_lanes;
                w_next         = (w_last_word && !CSUM_EN) ? S_SEND : S_POLL;
            end
            S_SEND: begin
                uart_write      = 1'b1;
                uart_address    = ADDR_TX_DATA;
                uart_write_data = r_resp;
                w_next          = (r_resp == RESP_ACK) ? S_DONE : S_ERROR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERROR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Byte assembly, counters, checksum, response selection and result flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase    <= PH_LENGTH;
            r_lanes    <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_len      <= '0;
            r_csum     <= '0;
            r_resp     <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_phase    <= PH_LENGTH;
                        r_byte_cnt <= '0;
                        r_word_cnt <= '0;
                        r_csum     <= '0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                S_READ: begin
                    if (r_phase == PH_CSUM) begin
                        r_resp <= w_csum_ok ? RESP_ACK : RESP_NAK;
                    end else begin
                        r_lanes[r_byte_cnt] <= w_byte;
                        r_byte_cnt          <= r_byte_cnt + 2'd1;
                        if (r_phase == PH_DATA) r_csum <= r_csum ^ w_byte;
                        if (w_last_lane && r_phase == PH_LENGTH) begin
                            if (w_len_big) begin
                                r_resp <= RESP_NAK;
                            end else if (w_len_zero) begin
                                r_resp <= RESP_ACK;
                                if (CSUM_EN) r_phase <= PH_CSUM;
                            end else begin
                                r_len   <= w_word[WCW-1:0];
                                r_phase <= PH_DATA;
                            end
                        end
                    end
                end
                S_STORE: begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    if (w_last_word) begin
                        r_resp <= RESP_ACK;
                        if (CSUM_EN) r_phase <= PH_CSUM;
                    end
                end
                S_DONE:  r_done  <= 1'b1;
                S_ERROR: r_error <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
